// File: rtl/sipo_deser_rx.sv
// -----------------------------------------------------------------------------
// sipo_deser_rx
//
// Serial-in parallel-out receiver. Rebuilds WIDTH-bit words (MSB first) from
// the serial stream of an upstream shifter. Every word begins with a bit
// qualified by `sof`. Finished words go into a 2-entry buffer. The buffer is
// drained through a valid/ready handshake. Framing and overflow problems are
// reported on sticky flags.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   si        serial data bit
//   si_valid  si carries a valid bit this cycle
//   sof       marks the first (MSB) bit of a word; sampled only with si_valid
//   po        word at the buffer head (registered)
//   po_valid  po holds a valid word (registered)
//   po_ready  consumer takes po this cycle
//   overflow  sticky: a completed word was dropped because the buffer was full
//   sync_err  sticky: sof arrived in the middle of a word
//   err_clr   synchronous clear of both sticky flags (a set in the same cycle wins)
//   bit_cnt   number of bits captured in the current partial word
// -----------------------------------------------------------------------------
module sipo_deser_rx #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         si,
    input  logic                         si_valid,
    input  logic                         sof,
    output logic [WIDTH-1:0]             po,
    output logic                         po_valid,
    input  logic                         po_ready,
    output logic                         overflow,
    output logic                         sync_err,
    input  logic                         err_clr,
    output logic [$clog2(WIDTH):0]       bit_cnt
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CW-1:0]      bit_cnt_q, bit_cnt_d;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;

    logic [WIDTH-1:0]   po_q, po_d;
    logic               po_valid_q, po_valid_d;
    logic               overflow_q, overflow_d;
    logic               sync_err_q, sync_err_d;

    logic               word_done;
    logic               sync_set;
    logic [WIDTH-1:0]   word;
    logic               pop;
    logic               push_ok;
    logic               ovf_set;

    // The assembled word is on the edge where its last bit arrives.
    assign word = {shift_q[WIDTH-2:0], si};

    // -------------------------------------------------------------------------
    // Framing FSM and shift register.
    // The MSB is loaded into bit 0 and moves left as more bits arrive. After
    // WIDTH bits it sits in bit WIDTH-1.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        word_done = 1'b0;
        sync_set  = 1'b0;
        case (state_q)
            IDLE: begin
                // Bits without sof are dropped while hunting for alignment.
                if (si_valid && sof) begin
                    shift_d   = {{(WIDTH-1){1'b0}}, si};
                    bit_cnt_d = CW'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (si_valid) begin
                    if (sof) begin
                        // Restart the word at this bit; the partial word is lost.
                        sync_set  = 1'b1;
                        shift_d   = {{(WIDTH-1){1'b0}}, si};
                        bit_cnt_d = CW'(1);
                    end else if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        word_done = 1'b1;
                        shift_d   = word;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        shift_d   = word;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output buffer. When the buffer is full, a push accepted together with a
    // pop overwrites the slot being popped: wr_ptr equals rd_ptr when full.
    // -------------------------------------------------------------------------
    assign pop     = po_valid_q && po_ready;
    assign push_ok = word_done && ((count_q != 2'd2) || pop);
    assign ovf_set = word_done && (count_q == 2'd2) && !pop;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            assign mem_d[gi] = (push_ok && (wr_ptr_q == 1'(gi))) ? word : mem_q[gi];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        wr_ptr_d = push_ok ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop     ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q + {1'b0, push_ok} - {1'b0, pop};

        // The outputs are registered from the next-state head. A word that
        // completes on edge N is then visible right after edge N.
        po_valid_d = (count_d != 2'd0);
        po_d       = po_valid_d ? mem_d[rd_ptr_d] : po_q;

        overflow_d = ovf_set  ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
        sync_err_d = sync_set ? 1'b1 : (err_clr ? 1'b0 : sync_err_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            po_q       <= '0;
            po_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            po_q       <= po_d;
            po_valid_q <= po_valid_d;
            overflow_q <= overflow_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign po       = po_q;
    assign po_valid = po_valid_q;
    assign overflow = overflow_q;
    assign sync_err = sync_err_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_sipo_deser_rx.sv
// -----------------------------------------------------------------------------
// tb_sipo_deser_rx
//
// Directed testbench for sipo_deser_rx with WIDTH=4. Inputs change 1 ns after
// each rising edge. Outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_sipo_deser_rx;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             si;
    logic             si_valid;
    logic             sof;
    logic [WIDTH-1:0] po;
    logic             po_valid;
    logic             po_ready;
    logic             overflow;
    logic             sync_err;
    logic             err_clr;
    logic [2:0]       bit_cnt;

    int checks = 0;
    int errors = 0;

    sipo_deser_rx #(.WIDTH(WIDTH), .DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .si       (si),
        .si_valid (si_valid),
        .sof      (sof),
        .po       (po),
        .po_valid (po_valid),
        .po_ready (po_ready),
        .overflow (overflow),
        .sync_err (sync_err),
        .err_clr  (err_clr),
        .bit_cnt  (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one serial bit for one cycle.
    task automatic drive_bit(input logic b, input logic f);
        si       = b;
        sof      = f;
        si_valid = 1'b1;
        tick();
        si_valid = 1'b0;
        sof      = 1'b0;
        si       = 1'b0;
    endtask

    // Send a whole word MSB first on consecutive cycles.
    task automatic send_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            drive_bit(w[i], (i == WIDTH - 1));
        end
    endtask

    initial begin
        rst      = 1'b0;
        si       = 1'b0;
        si_valid = 1'b0;
        sof      = 1'b0;
        po_ready = 1'b0;
        err_clr  = 1'b0;
        tick();
        tick();
        check("rst_po_valid", 32'(po_valid), 32'h0);
        check("rst_po",       32'(po),       32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_sync_err", 32'(sync_err), 32'h0);
        check("rst_bit_cnt",  32'(bit_cnt),  32'h0);
        rst = 1'b1;
        tick();

        // Reset in the middle of a word.
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b0);
        check("mid_bit_cnt", 32'(bit_cnt), 32'd2);
        rst = 1'b0;
        #1;
        check("mid_rst_bit_cnt", 32'(bit_cnt), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        // These bits would finish the old word if it had survived the reset.
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        tick();
        check("mid_no_word",  32'(po_valid), 32'h0);
        check("mid_bit_cnt0", 32'(bit_cnt),  32'd0);
        check("mid_flags",    32'({overflow, sync_err}), 32'h0);

        // Basic word 1010.
        po_ready = 1'b1;
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        check("basic_not_yet", 32'(po_valid), 32'h0);
        drive_bit(1'b0, 1'b0);
        check("basic_valid",   32'(po_valid), 32'h1);
        check("basic_po",      32'(po),       32'hA);
        tick();
        check("basic_popped",  32'(po_valid), 32'h0);
        check("basic_po_hold", 32'(po),       32'hA);

        // Stray bits in IDLE, then word 0110 with gaps.
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        check("stray_bit_cnt", 32'(bit_cnt), 32'd0);
        drive_bit(1'b0, 1'b1);
        tick();
        drive_bit(1'b1, 1'b0);
        tick();
        drive_bit(1'b1, 1'b0);
        tick();
        check("gap_bit_cnt", 32'(bit_cnt), 32'd3);
        drive_bit(1'b0, 1'b0);
        check("gap_valid", 32'(po_valid), 32'h1);
        check("gap_po",    32'(po),       32'h6);
        tick();
        check("gap_once",  32'(po_valid), 32'h0);

        // Backpressure and overflow.
        po_ready = 1'b0;
        send_word(4'b1100);
        check("bp_w1_valid", 32'(po_valid), 32'h1);
        check("bp_w1_po",    32'(po),       32'hC);
        send_word(4'b0011);
        check("bp_no_ovf",   32'(overflow), 32'h0);
        send_word(4'b1111);
        check("bp_overflow", 32'(overflow), 32'h1);
        check("bp_po_stable", 32'(po),      32'hC);
        po_ready = 1'b1;
        tick();
        check("bp_w2_valid", 32'(po_valid), 32'h1);
        check("bp_w2_po",    32'(po),       32'h3);
        tick();
        check("bp_empty",    32'(po_valid), 32'h0);
        check("bp_ovf_kept", 32'(overflow), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("bp_ovf_clr",  32'(overflow), 32'h0);

        // Full buffer; the third word completes on the same edge as a pop.
        po_ready = 1'b0;
        send_word(4'b1001);
        send_word(4'b0101);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        po_ready = 1'b1;
        drive_bit(1'b1, 1'b0);
        check("full_pop_no_ovf", 32'(overflow), 32'h0);
        check("full_pop_w2",     32'(po),       32'h5);
        tick();
        check("full_pop_w3_valid", 32'(po_valid), 32'h1);
        check("full_pop_w3",       32'(po),       32'h7);
        tick();
        check("full_pop_empty",    32'(po_valid), 32'h0);

        // Resync: sof in the middle of a word.
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b1);
        check("resync_err",     32'(sync_err), 32'h1);
        check("resync_bit_cnt", 32'(bit_cnt),  32'd1);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        check("resync_no_early", 32'(po_valid), 32'h0);
        drive_bit(1'b0, 1'b0);
        check("resync_valid", 32'(po_valid), 32'h1);
        check("resync_po",    32'(po),       32'hE);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("resync_only_one", 32'(po_valid), 32'h0);
        check("resync_clr",      32'(sync_err), 32'h0);

        // A set event wins over err_clr in the same cycle.
        drive_bit(1'b1, 1'b1);
        err_clr = 1'b1;
        drive_bit(1'b0, 1'b1);
        err_clr = 1'b0;
        check("set_wins", 32'(sync_err), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
